// File: rtl/vr_pkg.sv
// rtl/vr_pkg.sv - shared constants and helpers for the VR location path
package vr_pkg;

   localparam int C_LOC_W = 8;

   // Detector location value after reset; quantizers derive their reset position from it.
   localparam logic [C_LOC_W-1:0] C_LOC_MID = 8'h80;

   // Ceiling log2 for small elaboration-time counts.
   function automatic int vr_clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/vr_hyst_dec.sv
// rtl/vr_hyst_dec.sv - per-channel hysteresis band test and step qualification
module vr_hyst_dec
   import vr_pkg::*;
#(
   parameter int C_POS_W  = 3,
   parameter int C_HYST   = 4,
   parameter int C_STABLE = 3
) (
   input  logic [C_LOC_W-1:0] loc,
   input  logic [C_POS_W-1:0] pos,
   input  logic [C_POS_W-1:0] cand,
   input  logic [3:0]         cnt,
   output logic               out_of_band,
   output logic [C_POS_W-1:0] q,
   output logic [3:0]         cnt_nxt,
   output logic               commit_req
);

   localparam int BAND_SH = C_LOC_W - C_POS_W;
   localparam logic signed [9:0] HYST_S  = 10'(C_HYST);
   localparam logic signed [9:0] BAND_M1 = 10'((1 << BAND_SH) - 1);

   // Band edges are signed 10-bit so the lowest band's lower limit can go negative
   // and the highest band's upper limit can exceed 255 without wrapping.
   logic signed [9:0] loc_s;
   logic signed [9:0] lo_s;
   logic signed [9:0] lo_lim;
   logic signed [9:0] hi_lim;
   logic [4:0]        cnt_inc;

   assign loc_s   = $signed({2'b00, loc});
   assign lo_s    = $signed(10'(pos) << BAND_SH);
   assign lo_lim  = lo_s - HYST_S;
   assign hi_lim  = lo_s + BAND_M1 + HYST_S;
   assign out_of_band = (loc_s < lo_lim) || (loc_s > hi_lim);
   assign q       = loc[C_LOC_W-1 -: C_POS_W];
   assign cnt_inc = {1'b0, cnt} + 5'd1;

   // Count consecutive out-of-band scans that agree on the same target step.
   always_comb begin
      cnt_nxt    = 4'd0;
      commit_req = 1'b0;
      if (out_of_band) begin
         if ((q != cand) || (cnt == 4'd0)) begin
            cnt_nxt    = 4'd1;
            commit_req = (C_STABLE == 1);
         end else begin
            cnt_nxt    = cnt_inc[3:0];
            commit_req = (cnt_inc >= 5'(C_STABLE));
         end
      end
   end

endmodule

// File: rtl/vr_loc_quant.sv
// rtl/vr_loc_quant.sv - round-robin hysteresis quantizer with one-entry change event slot
module vr_loc_quant
   import vr_pkg::*;
#(
   parameter int C_CH_N   = 1,
   parameter int C_POS_W  = 3,
   parameter int C_HYST   = 4,
   parameter int C_STABLE = 3,
   localparam int C_CH_W  = (vr_clog2(C_CH_N) > 1) ? vr_clog2(C_CH_N) : 1
) (
   input  logic                        CK_i,
   input  logic                        XARST_i,
   input  logic                        EN_CK_i,
   input  logic [C_CH_N*C_LOC_W-1:0]   LOC_i,
   output logic [C_CH_N*C_POS_W-1:0]   POS_o,
   output logic                        CHG_VLD_o,
   input  logic                        CHG_RDY_i,
   output logic [C_CH_W-1:0]           CHG_CH_o,
   output logic [C_POS_W-1:0]          CHG_POS_o
);

   localparam logic [C_POS_W-1:0] POS_MID = C_LOC_MID[C_LOC_W-1 -: C_POS_W];

   logic [C_POS_W-1:0] pos_r  [C_CH_N];
   logic [C_POS_W-1:0] cand_r [C_CH_N];
   logic [3:0]         cnt_r  [C_CH_N];
   logic [C_CH_W-1:0]  idx_r;

   logic [C_LOC_W-1:0] loc_sel;
   logic [C_POS_W-1:0] pos_sel;
   logic [C_POS_W-1:0] cand_sel;
   logic [3:0]         cnt_sel;

   logic               dec_oob;
   logic [C_POS_W-1:0] dec_q;
   logic [3:0]         dec_cnt_nxt;
   logic               dec_commit;

   logic               slot_ok;
   logic               do_commit;
   logic               blocked;

   // Select the channel under evaluation by the scan index.
   always_comb begin
      loc_sel  = '0;
      pos_sel  = '0;
      cand_sel = '0;
      cnt_sel  = '0;
      for (int k = 0; k < C_CH_N; k++) begin
         if (idx_r == C_CH_W'(k)) begin
            loc_sel  = LOC_i[k*C_LOC_W +: C_LOC_W];
            pos_sel  = pos_r[k];
            cand_sel = cand_r[k];
            cnt_sel  = cnt_r[k];
         end
      end
   end

   vr_hyst_dec #(
      .C_POS_W  (C_POS_W),
      .C_HYST   (C_HYST),
      .C_STABLE (C_STABLE)
   ) u_dec (
      .loc         (loc_sel),
      .pos         (pos_sel),
      .cand        (cand_sel),
      .cnt         (cnt_sel),
      .out_of_band (dec_oob),
      .q           (dec_q),
      .cnt_nxt     (dec_cnt_nxt),
      .commit_req  (dec_commit)
   );

   // A commit may reuse the slot on the same edge it is being drained.
   assign slot_ok   = !CHG_VLD_o || CHG_RDY_i;
   assign do_commit = EN_CK_i && dec_commit && slot_ok;
   assign blocked   = EN_CK_i && dec_commit && !slot_ok;

   // Advance the scanner and update the evaluated channel's position/candidate/counter.
   always_ff @(posedge CK_i or negedge XARST_i) begin
      if (!XARST_i) begin
         idx_r <= '0;
         for (int k = 0; k < C_CH_N; k++) begin
            pos_r[k]  <= POS_MID;
            cand_r[k] <= '0;
            cnt_r[k]  <= '0;
         end
      end else if (EN_CK_i) begin
         idx_r <= (idx_r == C_CH_W'(C_CH_N - 1)) ? '0 : idx_r + 1'b1;
         for (int k = 0; k < C_CH_N; k++) begin
            if (idx_r == C_CH_W'(k)) begin
               if (dec_oob) cand_r[k] <= dec_q;
               if (do_commit) begin
                  pos_r[k] <= dec_q;
                  cnt_r[k] <= '0;
               end else if (blocked) begin
                  // Park one short of the threshold so the next scan retries with the latest q.
                  cnt_r[k] <= 4'(C_STABLE - 1);
               end else begin
                  cnt_r[k] <= dec_cnt_nxt;
               end
            end
         end
      end
   end

   // One-entry event register: load on commit, otherwise clear when accepted.
   always_ff @(posedge CK_i or negedge XARST_i) begin
      if (!XARST_i) begin
         CHG_VLD_o <= 1'b0;
         CHG_CH_o  <= '0;
         CHG_POS_o <= '0;
      end else if (do_commit) begin
         CHG_VLD_o <= 1'b1;
         CHG_CH_o  <= idx_r;
         CHG_POS_o <= dec_q;
      end else if (CHG_VLD_o && CHG_RDY_i) begin
         CHG_VLD_o <= 1'b0;
      end
   end

   // Flatten the committed positions onto the output bus.
   always_comb begin
      POS_o = '0;
      for (int k = 0; k < C_CH_N; k++) begin
         POS_o[k*C_POS_W +: C_POS_W] = pos_r[k];
      end
   end

endmodule

// File: tb/tb_vr_loc_quant.sv
// tb/tb_vr_loc_quant.sv - directed self-checking bench for vr_loc_quant
module tb_vr_loc_quant;

   logic        CK_i      = 1'b0;
   logic        XARST_i   = 1'b1;
   logic        EN_CK_i   = 1'b1;
   logic        CHG_RDY_i = 1'b1;
   logic [15:0] LOC_i     = 16'h8080;
   logic [5:0]  POS_o;
   logic        CHG_VLD_o;
   logic [0:0]  CHG_CH_o;
   logic [2:0]  CHG_POS_o;

   int n_cmp = 0;
   int n_bad = 0;

   vr_loc_quant #(
      .C_CH_N   (2),
      .C_POS_W  (3),
      .C_HYST   (4),
      .C_STABLE (3)
   ) dut (
      .CK_i      (CK_i),
      .XARST_i   (XARST_i),
      .EN_CK_i   (EN_CK_i),
      .LOC_i     (LOC_i),
      .POS_o     (POS_o),
      .CHG_VLD_o (CHG_VLD_o),
      .CHG_RDY_i (CHG_RDY_i),
      .CHG_CH_o  (CHG_CH_o),
      .CHG_POS_o (CHG_POS_o)
   );

   always #5 CK_i = ~CK_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CK_i);
   endtask

   task automatic quiet(input int n, input string tag);
      logic seen;
      seen = 1'b0;
      repeat (n) begin
         @(negedge CK_i);
         if (CHG_VLD_o !== 1'b0) seen = 1'b1;
      end
      check(tag, 32'(seen), 32'd0);
   endtask

   task automatic event_is(input string tag, input logic [0:0] ch, input logic [2:0] pos);
      check({tag, "_vld"}, 32'(CHG_VLD_o), 32'd1);
      check({tag, "_ch"},  32'(CHG_CH_o),  32'(ch));
      check({tag, "_pos"}, 32'(CHG_POS_o), 32'(pos));
   endtask

   initial begin
      // Reset
      #2 XARST_i = 1'b0;
      tick(2);
      check("rst_pos", 32'(POS_o), 32'h24);
      check("rst_vld", 32'(CHG_VLD_o), 32'd0);
      check("rst_ch",  32'(CHG_CH_o), 32'd0);
      check("rst_cpos", 32'(CHG_POS_o), 32'd0);
      XARST_i = 1'b1;
      quiet(100, "mid_hold_quiet");

      // Hysteresis on ch0
      LOC_i[7:0] = 8'h7E;
      quiet(6, "hyst_7e_quiet");
      LOC_i[7:0] = 8'h7B;
      tick(4);
      check("hyst_early", 32'(CHG_VLD_o), 32'd0);
      tick(1);
      event_is("hyst_ev", 1'b0, 3'd3);
      check("hyst_pos", 32'(POS_o), 32'h23);
      tick(1);
      check("hyst_drain", 32'(CHG_VLD_o), 32'd0);
      LOC_i[7:0] = 8'h7E;
      quiet(6, "hyst_back_quiet");

      // Glitch on ch1
      LOC_i[15:8] = 8'h40;
      quiet(4, "glitch_a_quiet");
      LOC_i[15:8] = 8'h80;
      quiet(2, "glitch_b_quiet");
      LOC_i[15:8] = 8'h40;
      tick(5);
      check("glitch_early", 32'(CHG_VLD_o), 32'd0);
      tick(1);
      event_is("glitch_ev", 1'b1, 3'd2);
      tick(1);
      check("glitch_drain", 32'(CHG_VLD_o), 32'd0);
      check("glitch_pos", 32'(POS_o), 32'h13);
      tick(1);

      // Backpressure
      CHG_RDY_i = 1'b0;
      LOC_i = 16'h10E0;
      tick(4);
      check("bp_early", 32'(CHG_VLD_o), 32'd0);
      tick(1);
      event_is("bp_ev0", 1'b0, 3'd7);
      check("bp_pos0", 32'(POS_o), 32'h17);
      tick(5);
      event_is("bp_hold", 1'b0, 3'd7);
      check("bp_pos_hold", 32'(POS_o), 32'h17);
      CHG_RDY_i = 1'b1;
      tick(1);
      check("bp_drain", 32'(CHG_VLD_o), 32'd0);
      tick(1);
      event_is("bp_ev1", 1'b1, 3'd0);
      tick(1);
      check("bp_drain1", 32'(CHG_VLD_o), 32'd0);
      check("bp_pos1", 32'(POS_o), 32'h07);
      tick(1);

      // End stops
      LOC_i = 16'h01FF;
      quiet(6, "end_ff_quiet");
      check("end_ff_pos", 32'(POS_o), 32'h07);
      LOC_i[7:0] = 8'h01;
      tick(4);
      check("end_01_early", 32'(CHG_VLD_o), 32'd0);
      tick(1);
      event_is("end_01_ev", 1'b0, 3'd0);
      tick(1);
      quiet(6, "end_01_quiet");
      check("end_01_pos", 32'(POS_o), 32'h00);

      // Clock enable freeze, then async reset with a pending event
      EN_CK_i   = 1'b0;
      CHG_RDY_i = 1'b0;
      LOC_i     = 16'hE0E0;
      tick(7);
      check("en_vld", 32'(CHG_VLD_o), 32'd0);
      check("en_pos", 32'(POS_o), 32'h00);
      EN_CK_i = 1'b1;
      tick(4);
      check("en_early", 32'(CHG_VLD_o), 32'd0);
      tick(1);
      event_is("en_ev", 1'b0, 3'd7);
      check("en_ev_pos", 32'(POS_o), 32'h07);
      tick(1);
      event_is("en_blocked", 1'b0, 3'd7);
      #2 XARST_i = 1'b0;
      #1;
      check("arst_vld", 32'(CHG_VLD_o), 32'd0);
      check("arst_pos", 32'(POS_o), 32'h24);
      check("arst_ch",  32'(CHG_CH_o), 32'd0);
      check("arst_cpos", 32'(CHG_POS_o), 32'd0);
      @(negedge CK_i);
      XARST_i = 1'b1;
      quiet(2, "arst_after_quiet");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
